// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with valid/ready handshakes
// and a 2-entry in-order output buffer. Each entry carries a tag.
// Optional macro LOGIC_UNIT_STATS_EN adds saturating op/illegal counters.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef LOGIC_UNIT_STATS_EN
  ,
  output logic [15:0]      op_count,
  output logic [7:0]       illegal_count
`endif
);

  // Entry layout: {illegal, zero, tag, result}
  localparam int unsigned ENT_W = WIDTH + TAG_W + 2;

  logic [1:0]       r_count;
  logic [ENT_W-1:0] r_slot0;   // head
  logic [ENT_W-1:0] r_slot1;   // second entry

  logic [WIDTH-1:0] w_result;
  logic             w_illegal;
  logic             w_zero;
  logic [ENT_W-1:0] w_entry;
  logic             w_push;
  logic             w_pop;

  // Decode the operation; illegal codes produce a zero result.
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (in_op)
      3'b111:  w_result = in_a & in_b;
      3'b110:  w_result = in_a | in_b;
      3'b100:  w_result = in_a ^ in_b;
      3'b000:  w_result = in_a & ~in_b;
      3'b001:  w_result = in_a | ~in_b;
      3'b010:  w_result = ~(in_a ^ in_b);
      default: w_illegal = 1'b1;
    endcase
    w_zero  = (w_result == '0);
    w_entry = {w_illegal, w_zero, in_tag, w_result};
  end

  assign in_ready  = (r_count != 2'd2) && !rst;
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Head outputs come straight from the head slot, which is zero when empty.
  assign out_result  = r_slot0[WIDTH-1:0];
  assign out_tag     = r_slot0[WIDTH +: TAG_W];
  assign out_zero    = r_slot0[WIDTH + TAG_W];
  assign out_illegal = r_slot0[WIDTH + TAG_W + 1];

  // Shift-style 2-entry FIFO; vacated slots are cleared so empty reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_slot0 <= w_entry;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_slot0 <= w_entry;
          end else if (w_push) begin
            r_slot1 <= w_entry;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_slot0 <= '0;
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_slot0 <= r_slot1;
            r_slot1 <= '0;
            r_count <= 2'd1;
          end
        end
      endcase
    end
  end

`ifdef LOGIC_UNIT_STATS_EN
  logic [15:0] r_op_count;
  logic [7:0]  r_illegal_count;

  // Saturating counters of accepted ops and accepted illegal ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count      <= 16'd0;
      r_illegal_count <= 8'd0;
    end else if (w_push) begin
      if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
      if (w_illegal && (r_illegal_count != 8'hFF))
        r_illegal_count <= r_illegal_count + 8'd1;
    end
  end

  assign op_count      = r_op_count;
  assign illegal_count = r_illegal_count;
`endif

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit for the RV32I datapath. Generalises the single-bit AND gate to WIDTH-bit operands and six operations selected by RISC-V funct3-style codes.
- Adds valid/ready handshakes on both sides and a 2-entry output buffer, so the execute stage can stall without dropping results.
- Sits beside the adder/shifter in the ALU. A tag travels with each operation.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 1..64).
- TAG_W, 5, width of the tag carried with each operation (destination register index).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept an operation this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  operation code
- in_tag  input  TAG_W  tag, passed through unchanged
- out_valid  output  1  result available at buffer head
- out_ready  input  1  consumer accepts head this cycle
- out_result  output  WIDTH  result
- out_zero  output  1  high when out_result is all zeros
- out_illegal  output  1  head entry carried an unsupported in_op
- out_tag  output  TAG_W  tag of head entry

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Handshakes:
  - Accept (push) when in_valid && in_ready at a rising edge.
  - Pop when out_valid && out_ready at a rising edge.
- Operation encoding (ops never use a carry path):
  - 111 AND a&b
  - 110 OR a|b
  - 100 XOR a^b
  - 000 ANDN a&~b
  - 001 ORN a|~b
  - 010 XNOR ~(a^b)
  - 011 and 101: illegal. Stored result is 0, out_illegal=1, out_zero=1.
- Datapath: result and out_zero are computed combinationally from the inputs and written into the buffer on accept. out_zero is stored per entry.
- Latency: an operation accepted at edge N appears at the head (out_valid=1) after edge N, provided the buffer was empty. Throughput is 1 op/cycle while the consumer keeps out_ready=1.
- Buffer:
  - 2-entry FIFO with count in 0..2. Order is strictly preserved.
  - in_ready = (count != 2) && !rst. in_ready does not depend combinationally on out_ready.
  - out_valid = (count != 0).
- Count transitions (push requires in_ready=1):
  - push only: count+1
  - pop only: count-1
  - push+pop at count=1: count stays 1; the old head leaves and the new entry becomes head
  - push+pop at count=0: impossible, because pop requires out_valid
  - count=2: no push can occur; a pop frees a slot, and in_ready rises on the next cycle
- Output stability: while out_valid=1 && out_ready=0, out_result, out_zero, out_illegal and out_tag hold stable.
- Empty buffer: head outputs read 0.
- Reset values (at the edge where rst=1):
  - count=0, out_valid=0, out_result=0, out_zero=0, out_illegal=0, out_tag=0
  - in_ready=0 while rst=1, then 1 in the first cycle after rst deasserts
  - Reset mid-operation discards every buffered entry; nothing is emitted afterwards.
- in_valid while in_ready=0: ignored. The unit holds no state for it, and the producer must hold its values.
- Widths: the result is exactly WIDTH bits. in_a, in_b and the result are unsigned bit vectors.

Optional Feature:
- Macro: LOGIC_UNIT_STATS_EN.
- Defined:
  - Adds output port op_count (16 bits), which counts accepted operations, including illegal ones, and saturates at 16'hFFFF.
  - Adds output port illegal_count (8 bits), which counts accepted illegal ops and saturates at 8'hFF.
  - Both counters reset to 0 on rst.
- Not defined: neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Reset then single op: WIDTH=32; in_a=32'hF0F0_1234, in_b=32'h0FF0_FFFF, op=111, tag=5, out_ready=1. Next cycle: out_valid=1, out_result=32'h00F0_1234, out_tag=5, out_zero=0. The following cycle: out_valid=0.
- All six ops plus both illegal codes with a=32'hAAAA_5555, b=32'h0000_FFFF, back-to-back, out_ready=1. Expect in order:
  - AND 0000_5555
  - OR AAAA_FFFF
  - XOR AAAA_AAAA
  - ANDN AAAA_0000
  - ORN FFFF_5555
  - XNOR 5555_5555
  - 011 → 0, out_illegal=1, out_zero=1
  - 101 → 0, out_illegal=1, out_zero=1
- Backpressure: out_ready=0, push 3 ops with tags 1, 2, 3. Tags 1 and 2 accepted; in_ready=0 after the second push; op 3 is held. Raise out_ready: outputs in tag order 1, 2, 3, and head values stay stable while stalled.
- Simultaneous push/pop at count=1 for 8 cycles with incrementing tags: count stays 1, in_ready stays 1, every tag emitted exactly once and in order.
- Reset mid-stream: fill the buffer (count=2), assert rst for 1 cycle. Then out_valid=0 and all outputs are 0. in_ready=1 one cycle after rst deasserts. No stale tag is ever emitted.
- With LOGIC_UNIT_STATS_EN defined: 70000 accepted ops, 300 of them illegal. Expect op_count=16'hFFFF and illegal_count=8'hFF. Both read 0 after rst.
